// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle DIV/DIVU unit: widths, FSM state codes
// and the divide-by-zero quotient.
package div_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [WIDTH-1:0] DZ_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/neg_cond_32b.sv
// Conditional two's-complement negate: O = en ? -A : A.
// Inverts through xor_32b, then adds en to finish the negation.
module neg_cond_32b (
  input  logic [31:0] A,
  input  logic        en,
  output logic [31:0] O
);
  logic [31:0] inv;

  xor_32b u_xor (
    .A (A),
    .B ({32{en}}),
    .O (inv)
  );

  assign O = inv + {31'd0, en};
endmodule

// File: rtl/xor_32b.sv
// Bitwise 32-bit XOR, the building block used for conditional inversion.
module xor_32b (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] O
);
  assign O = A ^ B;
endmodule

// File: rtl/div_32b.sv
// Restoring shift-subtract divider for MIPS DIV/DIVU, one quotient bit per clock.
// Quotient goes to Q (LO) and remainder to R (HI); divide by zero completes in one cycle.
module div_32b
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dz
);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, babs_q, babs_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

  logic             sa_in, sb_in;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0]   rem_sh, diff;

  assign sa_in = is_signed & A[WIDTH-1];
  assign sb_in = is_signed & B[WIDTH-1];

  neg_cond_32b u_neg_a (.A(A),     .en(sa_in),       .O(a_abs));
  neg_cond_32b u_neg_b (.A(B),     .en(sb_in),       .O(b_abs));
  neg_cond_32b u_neg_q (.A(quo_q), .en(sa_q ^ sb_q), .O(q_fix));
  neg_cond_32b u_neg_r (.A(rem_q), .en(sa_q),        .O(r_fix));

  // Shifted remainder needs 33 bits when the divisor magnitude exceeds 2^31.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, babs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    babs_d  = babs_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d   = sa_in;
          sb_d   = sb_in;
          quo_d  = a_abs;
          babs_d = b_abs;
          rem_d  = '0;
          cnt_d  = '0;
          if (B == '0) begin
            q_d     = DZ_QUOT;
            r_d     = A;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            q_d     = '0;
            r_d     = '0;
            dz_d    = 1'b0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        q_d     = q_fix;
        r_d     = r_fix;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      babs_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      babs_q  <= babs_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign Q    = q_q;
  assign R    = r_q;
  assign dz   = dz_q;
endmodule

// File: tb/tb_div_32b.sv
// Self-checking bench for div_32b: directed table, random ops against an
// arithmetic reference, ignored-start and mid-operation reset sequences.
module tb_div_32b;
  logic        clk = 1'b0;
  logic        rst, start, is_signed, busy, done, dz;
  logic [31:0] A, B, Q, R;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  div_32b dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .A(A), .B(B), .busy(busy), .done(done), .Q(Q), .R(R), .dz(dz)
  );

  typedef struct {
    logic [31:0] a, b;
    bit          s;
    logic [31:0] q, r;
    bit          dz;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: truncating division from plain 64-bit arithmetic.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] q, output logic [31:0] r, output bit z);
    longint la, lb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
      q = 32'(la / lb);
      r = 32'(la % lb);
    end
  endtask

  // Issue one op; returns done cycle (-1 on timeout) and whether busy held 1..done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    A = a; B = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; is_signed = $urandom_range(0, 1);
    lat = -1; busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (!busy) busy_ok = 1'b0;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic do_check(input string nm, input logic [31:0] a, input logic [31:0] b, input bit s,
                          input logic [31:0] eq, input logic [31:0] er, input bit edz, input int elat);
    int lat; bit bok;
    run_op(a, b, s, lat, bok);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_q"}, Q, eq);
    chk({nm, "_r"}, R, er);
    chk({nm, "_dz"}, {31'd0, dz}, {31'd0, edz});
    chk({nm, "_busy"}, {31'd0, bok}, 32'd1);
    @(posedge clk); #1;
    chk({nm, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] eq, er, a, b;
    bit ez, s;
    int cyc, ndone;

    vecs.push_back('{32'd100,        32'd7,          0, 32'd14,         32'd2,          0, 34});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 34});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1, 32'hFFFF_FFFD,  32'd1,          0, 34});
    vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1, 32'd3,          32'hFFFF_FFFF,  0, 34});
    vecs.push_back('{32'h1234_5678,  32'd0,          0, 32'hFFFF_FFFF,  32'h1234_5678,  1, 1});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1, 32'h8000_0000,  32'd0,          0, 34});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          0, 32'hFFFF_FFFF,  32'd0,          0, 34});
    vecs.push_back('{32'hFFFF_FFFF,  32'h8000_0000,  0, 32'd1,          32'h7FFF_FFFF,  0, 34});
    vecs.push_back('{32'hFFFF_FFF0,  32'd0,          1, 32'hFFFF_FFFF,  32'hFFFF_FFF0,  1, 1});
    vecs.push_back('{32'd3,          32'd10,         0, 32'd0,          32'd3,          0, 34});

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", Q, 32'd0);
    chk("rst_r", R, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      do_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
               vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = (i % 8 == 2) ? 32'd0 : -32'($urandom_range(1, 1000));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      s = $urandom_range(0, 1);
      ref_div(a, b, s, eq, er, ez);
      do_check($sformatf("rnd%0d", i), a, b, s, eq, er, ez, ez ? 1 : 34);
    end

    // Starts during an active op (cycle 5 and the done cycle) are ignored; cycle 35 is accepted.
    @(negedge clk);
    A = 32'd100; B = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ndone = 0; cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done && c < 34) ndone++;
      if (c == 34) begin
        chk("ign_done34", {31'd0, done}, 32'd1);
        chk("ign_q", Q, 32'd14);
        chk("ign_r", R, 32'd2);
        chk("ign_dz", {31'd0, dz}, 32'd0);
      end
      if (c > 35 && done) begin cyc = c; break; end
      case (c)
        5:  begin start = 1'b1; A = 32'd9; B = 32'd0; end
        6:  start = 1'b0;
        34: begin start = 1'b1; A = 32'd5; B = 32'd0; end
        35: begin A = 32'd1000; B = 32'd3; is_signed = 1'b0; end
        36: begin start = 1'b0; A = 32'd77; B = 32'd0; end
        default: ;
      endcase
    end
    chk("ign_early_done", ndone, 32'd0);
    chk("b2b_lat", cyc, 32'd69);
    chk("b2b_q", Q, 32'd333);
    chk("b2b_r", R, 32'd1);

    // Reset in cycle 10 of CALC aborts with no done.
    @(posedge clk); #1;
    @(negedge clk);
    A = 32'hDEAD_BEEF; B = 32'd17; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 2; c <= 10; c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", Q, 32'd0);
    chk("abort_r", R, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("abort_quiet", ndone, 32'd0);
    ref_div(32'hDEAD_BEEF, 32'd17, 1'b0, eq, er, ez);
    do_check("after_rst", 32'hDEAD_BEEF, 32'd17, 1'b0, eq, er, ez, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
